cache_read_extract: RTL and testbench

- Pipelined read-data path for the set-associative cache.
- Takes the per-way tag compare results and line data for the indexed set, selects the hitting way, and extracts a byte, halfword or word at the requested offset, with optional sign extension.
- Replaces the fixed 8-way / 256-bit / byte-only combinational select with a parametrised, two-stage, valid/ready pipeline that reports multi-hit and misalignment errors.
- Sits between the tag/data array read and the load writeback.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_read_extract_if.sv | 39 +++
 rtl/cache_way_select.sv | 45 ++++
 rtl/cache_read_extract.sv | 137 +++++++++++++
 tb/tb_cache_read_extract.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache read-data path: access size codes,
// error flag positions and a constant-width helper.
package cache_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  // Bit positions should the error causes be exported as a vector.
  localparam int ERR_MHIT     = 0;
  localparam int ERR_MISALIGN = 1;
  localparam int ERR_OVERSIZE = 2;
  localparam int ERR_W        = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/cache_read_extract_if.sv
// Request/response bundle for the cache read-extract pipeline.
interface cache_read_extract_if #(
  parameter int WAYS       = 8,
  parameter int LINE_BYTES = 32,
  parameter int DATA_BYTES = 4
);
  import cache_pkg::*;

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int DATA_W = DATA_BYTES * 8;
  localparam int OFF_W  = clog2(LINE_BYTES);
  localparam int WAY_W  = max1(clog2(WAYS));

  logic                     in_valid;
  logic                     in_ready;
  logic [WAYS-1:0]          tag_match;
  logic [WAYS-1:0]          way_valid;
  logic [WAYS*LINE_W-1:0]   line_data;
  logic [OFF_W-1:0]         offset;
  logic [1:0]               size;
  logic                     sign_ext;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_hit;
  logic [WAY_W-1:0]         out_way;
  logic [DATA_W-1:0]        out_data;
  logic                     out_err;

  modport master (
    output in_valid, tag_match, way_valid, line_data, offset, size, sign_ext, out_ready,
    input  in_ready, out_valid, out_hit, out_way, out_data, out_err
  );

  modport slave (
    input  in_valid, tag_match, way_valid, line_data, offset, size, sign_ext, out_ready,
    output in_ready, out_valid, out_hit, out_way, out_data, out_err
  );

endinterface

// File: rtl/cache_way_select.sv
// Combinational way selection: hit vector, lowest-index priority pick,
// multi-hit detect and one-hot AND-OR line mux (zero line on a miss).
module cache_way_select
  import cache_pkg::*;
#(
  parameter int WAYS       = 8,
  parameter int LINE_BYTES = 32,
  localparam int LINE_W    = LINE_BYTES * 8,
  localparam int WAY_W     = max1(clog2(WAYS))
) (
  input  logic [WAYS-1:0]        tag_match,
  input  logic [WAYS-1:0]        way_valid,
  input  logic [WAYS*LINE_W-1:0] line_data,
  output logic                   hit_any,
  output logic [WAY_W-1:0]       way,
  output logic                   mhit,
  output logic [LINE_W-1:0]      line
);

  logic [WAYS-1:0]   hit;
  logic [WAYS-1:0]   first;
  logic [LINE_W-1:0] masked [WAYS];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign hit[gi]    = tag_match[gi] & way_valid[gi];
      assign masked[gi] = line_data[gi*LINE_W +: LINE_W] & {LINE_W{first[gi]}};
    end
  endgenerate

  // Isolate the lowest set bit; any remaining bit means a second hit.
  assign first   = hit & ~(hit - WAYS'(1));
  assign mhit    = |(hit & (hit - WAYS'(1)));
  assign hit_any = |hit;

  always_comb begin
    way  = '0;
    line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (first[w]) way = way | WAY_W'(w);
      line = line | masked[w];
    end
  end

endmodule

// File: rtl/cache_read_extract.sv
// Two-stage valid/ready read path: S1 captures the hitting way's line,
// S2 extracts and extends the addressed byte/half/word and flags errors.
module cache_read_extract
  import cache_pkg::*;
#(
  parameter int WAYS       = 8,
  parameter int LINE_BYTES = 32,
  parameter int DATA_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_read_extract_if.slave  bus
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int DATA_W = DATA_BYTES * 8;
  localparam int OFF_W  = clog2(LINE_BYTES);
  localparam int WAY_W  = max1(clog2(WAYS));

  logic              sel_hit;
  logic [WAY_W-1:0]  sel_way;
  logic              sel_mhit;
  logic [LINE_W-1:0] sel_line;

  logic              s1_valid_reg;
  logic [LINE_W-1:0] s1_line_reg;
  logic              s1_hit_reg;
  logic [WAY_W-1:0]  s1_way_reg;
  logic [OFF_W-1:0]  s1_offset_reg;
  logic [1:0]        s1_size_reg;
  logic              s1_sign_reg;
  logic              s1_mhit_reg;

  logic              s2_valid_reg;
  logic              s2_hit_reg;
  logic [WAY_W-1:0]  s2_way_reg;
  logic [DATA_W-1:0] s2_data_reg;
  logic              s2_err_reg;

  logic              s1_adv;
  logic              s2_adv;
  int                nbytes;
  logic [DATA_W-1:0] slice;
  logic [DATA_W-1:0] ext;
  logic              msb;
  logic              misaligned;
  logic              oversize;
  logic [DATA_W-1:0] s2_data_next;
  logic              s2_err_next;

  cache_way_select #(
    .WAYS       (WAYS),
    .LINE_BYTES (LINE_BYTES)
  ) u_way_select (
    .tag_match (bus.tag_match),
    .way_valid (bus.way_valid),
    .line_data (bus.line_data),
    .hit_any   (sel_hit),
    .way       (sel_way),
    .mhit      (sel_mhit),
    .line      (sel_line)
  );

  assign s2_adv       = !s2_valid_reg || bus.out_ready;
  assign s1_adv       = !s1_valid_reg || s2_adv;
  assign bus.in_ready = s1_adv;

  // Bytes beyond the end of the line read as zero; such accesses are
  // always misaligned or oversize and get zeroed anyway.
  always_comb begin
    nbytes = 1 << s1_size_reg;
    slice  = '0;
    ext    = '0;
    msb    = 1'b0;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (int'(s1_offset_reg) + b < LINE_BYTES)
        slice[b*8 +: 8] = s1_line_reg[(int'(s1_offset_reg) + b)*8 +: 8];
    end
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (b == nbytes - 1) msb = slice[b*8 + 7];
    end
    for (int b = 0; b < DATA_BYTES; b++) begin
      ext[b*8 +: 8] = (b < nbytes) ? slice[b*8 +: 8] : {8{s1_sign_reg & msb}};
    end
    misaligned   = (int'(s1_offset_reg) & (nbytes - 1)) != 0;
    oversize     = nbytes > DATA_BYTES;
    s2_err_next  = s1_mhit_reg | misaligned | oversize;
    s2_data_next = (misaligned || oversize || !s1_hit_reg) ? '0 : ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg  <= 1'b0;
      s1_line_reg   <= '0;
      s1_hit_reg    <= 1'b0;
      s1_way_reg    <= '0;
      s1_offset_reg <= '0;
      s1_size_reg   <= '0;
      s1_sign_reg   <= 1'b0;
      s1_mhit_reg   <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s2_hit_reg    <= 1'b0;
      s2_way_reg    <= '0;
      s2_data_reg   <= '0;
      s2_err_reg    <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= bus.in_valid;
        if (bus.in_valid) begin
          s1_line_reg   <= sel_line;
          s1_hit_reg    <= sel_hit;
          s1_way_reg    <= sel_way;
          s1_offset_reg <= bus.offset;
          s1_size_reg   <= bus.size;
          s1_sign_reg   <= bus.sign_ext;
          s1_mhit_reg   <= sel_mhit;
        end
      end
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_hit_reg  <= s1_hit_reg;
          s2_way_reg  <= s1_way_reg;
          s2_data_reg <= s2_data_next;
          s2_err_reg  <= s2_err_next;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid_reg;
  assign bus.out_hit   = s2_hit_reg;
  assign bus.out_way   = s2_way_reg;
  assign bus.out_data  = s2_data_reg;
  assign bus.out_err   = s2_err_reg;

endmodule

// File: tb/tb_cache_read_extract.sv
// Scoreboard bench for cache_read_extract (8 ways, 32-byte lines, 4-byte data).
module tb_cache_read_extract;
  import cache_pkg::*;

  localparam int WAYS = 8;
  localparam int LB   = 32;
  localparam int DB   = 4;

  typedef struct {
    logic        hit;
    logic [2:0]  way;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_read_extract_if #(.WAYS(WAYS), .LINE_BYTES(LB), .DATA_BYTES(DB)) bus ();

  cache_read_extract #(.WAYS(WAYS), .LINE_BYTES(LB), .DATA_BYTES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  res_t exp_q[$];
  res_t rx_q[$];
  res_t exp_cur;
  logic [7:0] lb [WAYS][LB];

  logic        smp_valid, smp_ready, smp_in_ready, smp_hit, smp_err;
  logic [2:0]  smp_way;
  logic [31:0] smp_data;
  logic        prv_valid, prv_ready, prv_hit, prv_err;
  logic [2:0]  prv_way;
  logic [31:0] prv_data;

  function automatic res_t mk(input logic h, input int w, input logic [31:0] d, input logic e);
    res_t r;
    r.hit = h; r.way = 3'(w); r.data = d; r.err = e; r.cyc = 0;
    return r;
  endfunction

  function automatic string rs(input res_t r);
    return $sformatf("hit=%0b way=%0d data=%08h err=%0b", r.hit, r.way, r.data, r.err);
  endfunction

  task automatic pack_lines();
    for (int w = 0; w < WAYS; w++)
      for (int k = 0; k < LB; k++)
        bus.line_data[(w*LB + k)*8 +: 8] = lb[w][k];
  endtask

  task automatic load_lines();
    for (int w = 0; w < WAYS; w++)
      for (int k = 0; k < LB; k++)
        lb[w][k] = 8'(w*16 + k);
    pack_lines();
  endtask

  task automatic drive(input logic [7:0] tm, input logic [7:0] vm, input int off, input int sz,
                       input logic sx, input res_t e);
    bus.in_valid  = 1'b1;
    bus.tag_match = tm;
    bus.way_valid = vm;
    bus.offset    = 5'(off);
    bus.size      = 2'(sz);
    bus.sign_ext  = sx;
    exp_cur       = e;
  endtask

  // Advance one cycle: sample at the falling edge, log handshakes, then step past the rising edge.
  task automatic step(output bit acc);
    res_t r;
    @(negedge clk);
    prv_valid = smp_valid; prv_ready = smp_ready; prv_hit = smp_hit;
    prv_err = smp_err; prv_way = smp_way; prv_data = smp_data;
    smp_valid = bus.out_valid; smp_ready = bus.out_ready; smp_in_ready = bus.in_ready;
    smp_hit = bus.out_hit; smp_err = bus.out_err; smp_way = bus.out_way; smp_data = bus.out_data;
    acc = bus.in_valid && bus.in_ready && !reset;
    if (acc) begin
      exp_cur.cyc = cyc;
      exp_q.push_back(exp_cur);
    end
    if (bus.out_valid && bus.out_ready && !reset) begin
      r.hit = bus.out_hit; r.way = bus.out_way; r.data = bus.out_data;
      r.err = bus.out_err; r.cyc = cyc;
      rx_q.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int n, output bit timeout);
    bit acc;
    bus.in_valid = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (rx_q.size() >= n) begin
        timeout = 1'b0;
        break;
      end
      step(acc);
    end
  endtask

  task automatic test_reset();
    bit acc;
    reset = 1'b1;
    step(acc);
    step(acc);
    reset = 1'b0;
    step(acc);
    total++;
    if (smp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %0b want 0", smp_valid);
    end
    total++;
    if ({smp_hit, smp_way, smp_data, smp_err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got hit=%0b way=%0d data=%08h err=%0b want all 0",
                      smp_hit, smp_way, smp_data, smp_err);
    end
    total++;
    if (smp_in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %0b want 1", smp_in_ready);
    end
    $display("reset: out_valid=%0b in_ready=%0b", smp_valid, smp_in_ready);
  endtask

  task automatic test_basic();
    bit acc, to;
    res_t e, r;
    load_lines();
    for (int k = 0; k < LB; k++) lb[3][k] = 8'(k + 8'h40);
    pack_lines();
    drive(8'h08, 8'hFF, 5, 0, 1'b0, mk(1'b1, 3, 32'h0000_0045, 1'b0));
    step(acc);
    drain(1, to);
    total++;
    if (to || exp_q.size() != 1) begin
      bad++; $display("FAIL basic_timeout: got rx=%0d exp=%0d want 1 each", rx_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      $display("basic: %s", rs(r));
      if (r.hit !== e.hit || r.way !== e.way || r.data !== e.data || r.err !== e.err) begin
        bad++; $display("FAIL basic_data: got %s want %s", rs(r), rs(e));
      end
      total++;
      if (r.cyc - e.cyc != 2) begin
        bad++; $display("FAIL basic_latency: got %0d want 2", r.cyc - e.cyc);
      end
    end
  endtask

  task automatic test_sizes();
    bit acc, to;
    int nacc;
    res_t e, r;
    lb[1][8] = 8'h80; lb[1][9] = 8'h81; lb[1][10] = 8'h82; lb[1][11] = 8'hF3;
    pack_lines();
    nacc = 0;
    drive(8'h02, 8'hFF, 8, 2, 1'b0, mk(1'b1, 1, 32'hF382_8180, 1'b0)); step(acc); nacc += int'(acc);
    drive(8'h02, 8'hFF, 8, 1, 1'b1, mk(1'b1, 1, 32'hFFFF_8180, 1'b0)); step(acc); nacc += int'(acc);
    drive(8'h02, 8'hFF, 8, 0, 1'b0, mk(1'b1, 1, 32'h0000_0080, 1'b0)); step(acc); nacc += int'(acc);
    total++;
    if (nacc != 3) begin
      bad++; $display("FAIL sizes_throughput: got %0d accepts want 3", nacc);
    end
    drain(3, to);
    total++;
    if (to) begin
      bad++; $display("FAIL sizes_timeout: got rx=%0d want 3", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      $display("sizes: %s", rs(r));
      total++;
      if (r.hit !== e.hit || r.way !== e.way || r.data !== e.data || r.err !== e.err) begin
        bad++; $display("FAIL sizes_data: got %s want %s", rs(r), rs(e));
      end
    end
  endtask

  task automatic test_miss_mhit();
    bit acc, to;
    res_t e, r;
    load_lines();
    drive(8'hFF, 8'h00, 3, 0, 1'b0, mk(1'b0, 0, 32'h0, 1'b0)); step(acc);
    drive(8'h24, 8'h24, 4, 0, 1'b0, mk(1'b1, 2, 32'h0000_0024, 1'b1)); step(acc);
    drain(2, to);
    total++;
    if (to) begin
      bad++; $display("FAIL miss_timeout: got rx=%0d want 2", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      $display("miss/mhit: %s", rs(r));
      total++;
      if (r.hit !== e.hit || r.way !== e.way || r.data !== e.data || r.err !== e.err) begin
        bad++; $display("FAIL miss_mhit: got %s want %s", rs(r), rs(e));
      end
    end
  endtask

  task automatic test_errors_boundary();
    bit acc, to;
    res_t e, r;
    // Way 7 bytes 28..31 are 0x8C..0x8F: last aligned word and half of the line.
    drive(8'h02, 8'hFF, 6,  2, 1'b0, mk(1'b1, 1, 32'h0, 1'b1)); step(acc);
    drive(8'h02, 8'hFF, 0,  3, 1'b0, mk(1'b1, 1, 32'h0, 1'b1)); step(acc);
    drive(8'h80, 8'hFF, 28, 2, 1'b0, mk(1'b1, 7, 32'h8F8E_8D8C, 1'b0)); step(acc);
    drive(8'h80, 8'hFF, 30, 1, 1'b1, mk(1'b1, 7, 32'hFFFF_8F8E, 1'b0)); step(acc);
    drive(8'h80, 8'hFF, 31, 1, 1'b1, mk(1'b1, 7, 32'h0, 1'b1)); step(acc);
    drain(5, to);
    total++;
    if (to) begin
      bad++; $display("FAIL errors_timeout: got rx=%0d want 5", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      $display("errors/boundary: %s", rs(r));
      total++;
      if (r.hit !== e.hit || r.way !== e.way || r.data !== e.data || r.err !== e.err) begin
        bad++; $display("FAIL errors_boundary: got %s want %s", rs(r), rs(e));
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc, to, saw_block;
    int i;
    res_t e, r;
    logic [31:0] w;
    load_lines();
    i = 0;
    saw_block = 1'b0;
    for (int j = 0; j < 14; j++) begin
      bus.out_ready = !(j >= 3 && j <= 6);
      if (i < 5) begin
        w = {lb[i][4*i+3], lb[i][4*i+2], lb[i][4*i+1], lb[i][4*i]};
        drive(8'(1 << i), 8'hFF, 4*i, 2, 1'b0, mk(1'b1, i, w, 1'b0));
      end else begin
        bus.in_valid = 1'b0;
      end
      step(acc);
      if (acc) i++;
      if (bus.in_valid && !smp_in_ready) saw_block = 1'b1;
      if (prv_valid && !prv_ready) begin
        total++;
        if (smp_valid !== 1'b1 || smp_data !== prv_data || smp_way !== prv_way ||
            smp_hit !== prv_hit || smp_err !== prv_err) begin
          bad++; $display("FAIL bp_stable: got valid=%0b data=%08h way=%0d want valid=1 data=%08h way=%0d",
                          smp_valid, smp_data, smp_way, prv_data, prv_way);
        end
      end
    end
    bus.out_ready = 1'b1;
    total++;
    if (!saw_block) begin
      bad++; $display("FAIL bp_in_ready: got in_ready never low want low while stalled");
    end
    drain(5, to);
    for (int k = 0; k < 8; k++) step(acc);
    total++;
    if (rx_q.size() != 5 || exp_q.size() != 5) begin
      bad++; $display("FAIL bp_count: got rx=%0d exp=%0d want 5 each", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      $display("backpressure: %s", rs(r));
      total++;
      if (r.hit !== e.hit || r.way !== e.way || r.data !== e.data || r.err !== e.err) begin
        bad++; $display("FAIL bp_order: got %s want %s", rs(r), rs(e));
      end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_reset_midflight();
    bit acc, to, saw_valid;
    res_t e, r;
    bus.out_ready = 1'b1;
    drive(8'h10, 8'hFF, 4, 2, 1'b0, mk(1'b1, 4, 32'h4746_4544, 1'b0)); step(acc);
    drive(8'h20, 8'hFF, 8, 2, 1'b0, mk(1'b1, 5, 32'h5B5A_5958, 1'b0));
    reset = 1'b1;
    step(acc);
    saw_valid = smp_valid;
    bus.in_valid = 1'b0;
    step(acc);
    reset = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      step(acc);
      if (smp_valid) saw_valid = 1'b1;
    end
    total++;
    if (saw_valid || rx_q.size() != 0) begin
      bad++; $display("FAIL rst_flight: got out_valid=%0b rx=%0d want 0 and 0", saw_valid, rx_q.size());
    end
    rx_q.delete();
    drive(8'h40, 8'hFF, 12, 1, 1'b1, mk(1'b1, 6, 32'h0000_6D6C, 1'b0)); step(acc);
    drain(1, to);
    total++;
    if (to || exp_q.size() != 1) begin
      bad++; $display("FAIL rst_after_timeout: got rx=%0d exp=%0d want 1 each", rx_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      $display("after reset: %s latency=%0d", rs(r), r.cyc - e.cyc);
      if (r.hit !== e.hit || r.way !== e.way || r.data !== e.data || r.err !== e.err) begin
        bad++; $display("FAIL rst_after_data: got %s want %s", rs(r), rs(e));
      end
      total++;
      if (r.cyc - e.cyc != 2) begin
        bad++; $display("FAIL rst_after_latency: got %0d want 2", r.cyc - e.cyc);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.tag_match = '0;
    bus.way_valid = '0;
    bus.line_data = '0;
    bus.offset    = '0;
    bus.size      = '0;
    bus.sign_ext  = 1'b0;
    smp_valid = 0; smp_ready = 0; smp_in_ready = 0; smp_hit = 0; smp_err = 0; smp_way = 0; smp_data = 0;
    prv_valid = 0; prv_ready = 0; prv_hit = 0; prv_err = 0; prv_way = 0; prv_data = 0;
    load_lines();
    test_reset();
    test_basic();
    test_sizes();
    test_miss_mhit();
    test_errors_boundary();
    test_backpressure();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
